instr_fetch: RTL



---
 rtl/rk8_fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 53 +++++
 rtl/instr_fetch.sv | 81 ++++++++
 3 files changed

// File: rtl/rk8_fetch_pkg.sv
// Shared types and widths for the ROM-fed instruction fetch stage.
package rk8_fetch_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 32;

    typedef enum logic {
        GUARD = 1'b0,
        WAIT  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of {pc, word}; slot 0 is always the head so the output is a plain register.
module fetch_fifo
    import rk8_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t slot_reg  [2];
    fetch_entry_t slot_next [2];
    logic [1:0]   count_reg, count_next;
    logic         do_push, do_pop, wr_sel;

    always_comb begin
        do_pop     = pop && (count_reg != 2'd0) && !flush;
        do_push    = push && !flush && ((count_reg != 2'd2) || do_pop);
        // Tail slot after any same-cycle pop has shifted the queue down.
        wr_sel     = (count_reg == 2'd2) || ((count_reg == 2'd1) && !do_pop);
        count_next = flush ? 2'd0
                           : count_reg + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_comb begin
        slot_next = slot_reg;
        if (do_pop) begin
            slot_next[0] = slot_reg[1];
        end
        if (do_push) begin
            slot_next[wr_sel] = push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg   <= 2'd0;
            slot_reg[0] <= '0;
            slot_reg[1] <= '0;
        end else begin
            count_reg <= count_next;
            slot_reg  <= slot_next;
        end
    end

    assign count = count_reg;
    assign head  = slot_reg[0];

endmodule

// File: rtl/instr_fetch.sv
// Sequential fetch stage: drives the ROM address, captures qualified words into a
// 2-entry queue toward the decoder, and restarts on a single-cycle redirect.
module instr_fetch
    import rk8_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 24'h000000,
    parameter logic [ADDR_W-1:0] ADDR_STEP = 24'd4
)
(
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              rom_readyn,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready
);

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] rom_addr_reg, rom_addr_next;
    logic              capture, pop;
    logic [1:0]        count;
    fetch_entry_t      head, push_entry;

    assign instr_valid = (count != 2'd0);
    assign pop         = instr_valid && instr_ready;
    assign push_entry  = '{pc: rom_addr_reg, word: rom_data};

    always_comb begin
        state_next    = state_reg;
        rom_addr_next = rom_addr_reg;
        capture       = 1'b0;
        if (redirect) begin
            state_next    = GUARD;
            rom_addr_next = redirect_pc;
        end else begin
            case (state_reg)
                GUARD: state_next = WAIT;
                WAIT: begin
                    // A full queue holds the address so the ROM keeps presenting this word.
                    if (!rom_readyn && ((count != 2'd2) || pop)) begin
                        capture       = 1'b1;
                        rom_addr_next = rom_addr_reg + ADDR_STEP;
                        state_next    = GUARD;
                    end
                end
                default: state_next = GUARD;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= GUARD;
            rom_addr_reg <= RESET_PC;
        end else begin
            state_reg    <= state_next;
            rom_addr_reg <= rom_addr_next;
        end
    end

    fetch_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (capture),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect),
        .count     (count),
        .head      (head)
    );

    assign rom_addr = rom_addr_reg;
    assign instr    = head.word;
    assign instr_pc = head.pc;

endmodule
